// File: rtl/sump_serial_pkg.sv
// Shared encodings for the SUMP serial command receiver.
package sump_serial_pkg;

   localparam int unsigned SUMP_LONG_CMD_BIT = 7;
   localparam int unsigned SUMP_DATA_BYTES   = 4;

   // Bit-level UART receive states
   typedef enum logic [1:0] {
      BIT_IDLE  = 2'd0,
      BIT_START = 2'd1,
      BIT_DATA  = 2'd2,
      BIT_STOP  = 2'd3
   } bit_state_t;

   // Command assembly states
   typedef enum logic {
      CMD_WAIT_OP   = 1'b0,
      CMD_WAIT_DATA = 1'b1
   } cmd_state_t;

   // Long commands carry four data bytes after the opcode
   function automatic logic is_long_cmd(input logic [7:0] i_opcode);
      return i_opcode[SUMP_LONG_CMD_BIT];
   endfunction

endpackage

// File: rtl/serial_rx_byte.sv
// 8N1 byte deserialiser: 2-FF synchroniser on rx followed by the bit FSM.
// With SERIAL_RX_TIMEOUT_EN defined, also exports o_active_c (bit FSM busy).
module serial_rx_byte
   import sump_serial_pkg::*;
#(
   parameter int unsigned BITLENGTH = 868,
   parameter int unsigned CNT_W     = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
`ifdef SERIAL_RX_TIMEOUT_EN
   output logic       o_active_c,
`endif
   output logic [7:0] o_rx_byte,
   output logic       o_byte_valid_c,
   output logic       o_framing_error_c
);

   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BITLENGTH / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BITLENGTH - 1);

   logic             r_rx_meta;
   logic             r_rx_s;
   bit_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_err_hold;

   bit_state_t       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [2:0]       w_bit_idx_nxt;
   logic [7:0]       w_shift_nxt;
   logic             w_err_hold_nxt;

   // Two-flop synchroniser; resets to the idle-high line level
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= i_rx;
         r_rx_s    <= r_rx_meta;
      end
   end

   // Bit FSM state and datapath registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= BIT_IDLE;
         r_cnt      <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_err_hold <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_bit_idx  <= w_bit_idx_nxt;
         r_shift    <= w_shift_nxt;
         r_err_hold <= w_err_hold_nxt;
      end
   end

   // Next-state and strobe decode; samples land mid-bit
   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt + CNT_W'(1);
      w_bit_idx_nxt     = r_bit_idx;
      w_shift_nxt       = r_shift;
      w_err_hold_nxt    = r_err_hold;
      o_byte_valid_c    = 1'b0;
      o_framing_error_c = 1'b0;
      case (r_state)
         BIT_IDLE: begin
            w_cnt_nxt     = '0;
            w_bit_idx_nxt = '0;
            if (!r_rx_s) w_state_nxt = BIT_START;
         end
         BIT_START: begin
            if (r_cnt == HALF_M1) begin
               w_cnt_nxt   = '0;
               w_state_nxt = r_rx_s ? BIT_IDLE : BIT_DATA;
            end
         end
         BIT_DATA: begin
            if (r_cnt == BIT_M1) begin
               w_cnt_nxt     = '0;
               w_shift_nxt   = {r_rx_s, r_shift[7:1]};
               w_bit_idx_nxt = r_bit_idx + 3'd1;
               if (r_bit_idx == 3'd7) w_state_nxt = BIT_STOP;
            end
         end
         BIT_STOP: begin
            if (r_err_hold) begin
               // Broken frame: wait for the line to return high
               w_cnt_nxt = '0;
               if (r_rx_s) begin
                  w_err_hold_nxt = 1'b0;
                  w_state_nxt    = BIT_IDLE;
               end
            end else if (r_cnt == BIT_M1) begin
               w_cnt_nxt = '0;
               if (r_rx_s) begin
                  o_byte_valid_c = 1'b1;
                  w_state_nxt    = BIT_IDLE;
               end else begin
                  o_framing_error_c = 1'b1;
                  w_err_hold_nxt    = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = BIT_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_rx_byte = r_shift;

`ifdef SERIAL_RX_TIMEOUT_EN
   // Any activity after idle counts as a start bit for the command timeout
   assign o_active_c = (r_state != BIT_IDLE);
`endif

endmodule

// File: rtl/serial_receiver.sv
// SUMP command receiver: assembles 1-byte short and 5-byte long commands.
// Optional macro SERIAL_RX_TIMEOUT_EN drops a stalled partial long command.
module serial_receiver
   import sump_serial_pkg::*;
#(
   parameter int unsigned FREQ         = 100000000,
   parameter int unsigned RATE         = 115200,
   parameter int unsigned TIMEOUT_BITS = 32
) (
   input  logic        clock,
   input  logic        extReset,
   input  logic        rx,
   output logic [7:0]  op,
   output logic [31:0] data,
   output logic        execute,
   output logic        framing_error
);

   localparam int unsigned BITLENGTH = FREQ / RATE;
   localparam int unsigned CNT_W     = $clog2(BITLENGTH * TIMEOUT_BITS) + 1;
   localparam logic [1:0]  LAST_IDX  = 2'(SUMP_DATA_BYTES - 1);

   logic [7:0]  w_rx_byte;
   logic        w_rx_valid;
   logic        w_rx_ferr;

   cmd_state_t  r_cmd_state;
   logic [1:0]  r_cnt_byte;
   logic [7:0]  r_op_sh;
   logic [31:0] r_data_sh;
   logic [7:0]  r_op;
   logic [31:0] r_data;
   logic        r_execute;
   logic        r_framing_error;

   cmd_state_t  w_cmd_state_nxt;
   logic [1:0]  w_cnt_byte_nxt;
   logic [7:0]  w_op_sh_nxt;
   logic [31:0] w_data_sh_nxt;
   logic [7:0]  w_op_nxt;
   logic [31:0] w_data_nxt;
   logic        w_execute_nxt;
   logic        w_framing_error_nxt;

`ifdef SERIAL_RX_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT_BITS * BITLENGTH - 1);
   logic             w_active;
   logic [CNT_W-1:0] r_timer;
   logic [CNT_W-1:0] w_timer_nxt;
`endif

   serial_rx_byte #(
      .BITLENGTH (BITLENGTH),
      .CNT_W     (CNT_W)
   ) u_rx_byte (
      .i_clk             (clock),
      .i_rst             (extReset),
      .i_rx              (rx),
`ifdef SERIAL_RX_TIMEOUT_EN
      .o_active_c        (w_active),
`endif
      .o_rx_byte         (w_rx_byte),
      .o_byte_valid_c    (w_rx_valid),
      .o_framing_error_c (w_rx_ferr)
   );

   // Command FSM state, shadow registers and registered outputs
   always_ff @(posedge clock) begin
      if (extReset) begin
         r_cmd_state     <= CMD_WAIT_OP;
         r_cnt_byte      <= '0;
         r_op_sh         <= '0;
         r_data_sh       <= '0;
         r_op            <= '0;
         r_data          <= '0;
         r_execute       <= 1'b0;
         r_framing_error <= 1'b0;
      end else begin
         r_cmd_state     <= w_cmd_state_nxt;
         r_cnt_byte      <= w_cnt_byte_nxt;
         r_op_sh         <= w_op_sh_nxt;
         r_data_sh       <= w_data_sh_nxt;
         r_op            <= w_op_nxt;
         r_data          <= w_data_nxt;
         r_execute       <= w_execute_nxt;
         r_framing_error <= w_framing_error_nxt;
      end
   end

`ifdef SERIAL_RX_TIMEOUT_EN
   // Idle-time counter while a long command is incomplete
   always_ff @(posedge clock) begin
      if (extReset) r_timer <= '0;
      else          r_timer <= w_timer_nxt;
   end
`endif

   // Command assembly; op/data only move together with execute
   always_comb begin
      w_cmd_state_nxt     = r_cmd_state;
      w_cnt_byte_nxt      = r_cnt_byte;
      w_op_sh_nxt         = r_op_sh;
      w_data_sh_nxt       = r_data_sh;
      w_op_nxt            = r_op;
      w_data_nxt          = r_data;
      w_execute_nxt       = 1'b0;
      w_framing_error_nxt = 1'b0;
`ifdef SERIAL_RX_TIMEOUT_EN
      w_timer_nxt         = '0;
`endif
      if (w_rx_ferr) begin
         w_framing_error_nxt = 1'b1;
         w_cmd_state_nxt     = CMD_WAIT_OP;
         w_cnt_byte_nxt      = '0;
      end else if (w_rx_valid) begin
         case (r_cmd_state)
            CMD_WAIT_OP: begin
               if (is_long_cmd(w_rx_byte)) begin
                  w_op_sh_nxt     = w_rx_byte;
                  w_cnt_byte_nxt  = '0;
                  w_cmd_state_nxt = CMD_WAIT_DATA;
               end else begin
                  w_op_nxt      = w_rx_byte;
                  w_execute_nxt = 1'b1;
               end
            end
            CMD_WAIT_DATA: begin
               // Bytes arrive LSB first; shifting down leaves b1 in [7:0]
               w_data_sh_nxt = {w_rx_byte, r_data_sh[31:8]};
               if (r_cnt_byte == LAST_IDX) begin
                  w_op_nxt        = r_op_sh;
                  w_data_nxt      = {w_rx_byte, r_data_sh[31:8]};
                  w_execute_nxt   = 1'b1;
                  w_cnt_byte_nxt  = '0;
                  w_cmd_state_nxt = CMD_WAIT_OP;
               end else begin
                  w_cnt_byte_nxt = r_cnt_byte + 2'd1;
               end
            end
            default: begin
               w_cmd_state_nxt = CMD_WAIT_OP;
               w_cnt_byte_nxt  = '0;
            end
         endcase
      end
`ifdef SERIAL_RX_TIMEOUT_EN
      else if (r_cmd_state == CMD_WAIT_DATA && !w_active) begin
         if (r_timer == TIMEOUT_M1) begin
            w_cmd_state_nxt = CMD_WAIT_OP;
            w_cnt_byte_nxt  = '0;
         end else begin
            w_timer_nxt = r_timer + CNT_W'(1);
         end
      end
`endif
   end

   assign op            = r_op;
   assign data          = r_data;
   assign execute       = r_execute;
   assign framing_error = r_framing_error;

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver at FREQ=16, RATE=1 (16 cycles per bit).
// Expected commands are queued when their final byte is sent and checked
// by a monitor when execute fires.
`timescale 1ns/1ps
module tb_serial_receiver;

   localparam int unsigned FREQ         = 16;
   localparam int unsigned RATE         = 1;
   localparam int unsigned TIMEOUT_BITS = 32;
   localparam int unsigned BITLEN       = FREQ / RATE;
   // start edge -> 2 sync flops -> idle detect -> half bit -> 8 data bits -> stop sample -> register
   localparam int          FRAME_LAT    = 2 + 1 + (BITLEN / 2) + 8 * BITLEN + BITLEN - 1 + 1;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   logic        clock = 1'b0;
   logic        extReset;
   logic        rx;
   logic [7:0]  op;
   logic [31:0] data;
   logic        execute;
   logic        framing_error;

   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   exec_cnt = 0;
   int   fe_cnt   = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   serial_receiver #(
      .FREQ         (FREQ),
      .RATE         (RATE),
      .TIMEOUT_BITS (TIMEOUT_BITS)
   ) dut (
      .clock         (clock),
      .extReset      (extReset),
      .rx            (rx),
      .op            (op),
      .data          (data),
      .execute       (execute),
      .framing_error (framing_error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: every execute must match the oldest queued command
   always @(negedge clock) begin
      if (execute === 1'b1) begin
         exec_cnt++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_execute op=%h data=%h cycle=%0d", op, data, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            checks += 3;
            if (op !== mon_e.op) begin
               errors++;
               $display("FAIL exec_op got=%h exp=%h", op, mon_e.op);
            end
            if (data !== mon_e.data) begin
               errors++;
               $display("FAIL exec_data got=%h exp=%h", data, mon_e.data);
            end
            if (cyc !== mon_e.cyc) begin
               errors++;
               $display("FAIL exec_latency got_cycle=%0d exp_cycle=%0d", cyc, mon_e.cyc);
            end
         end
      end
      if (framing_error === 1'b1) fe_cnt++;
      if (execute === 1'b1 || framing_error === 1'b1) begin
         checks++;
         if (execute === 1'b1 && framing_error === 1'b1) begin
            errors++;
            $display("FAIL strobe_overlap execute=%b framing_error=%b", execute, framing_error);
         end
      end
   end

   task automatic idle_cycles(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   // One 8N1 frame; optionally queue the command it completes
   task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                            input logic exp_exec, input logic [7:0] eop,
                            input logic [31:0] edata);
      exp_t x;
      @(negedge clock);
      if (exp_exec) begin
         x.op   = eop;
         x.data = edata;
         x.cyc  = cyc + FRAME_LAT;
         sb_q.push_back(x);
      end
      rx = 1'b0;
      repeat (BITLEN) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BITLEN) @(negedge clock);
      end
      rx = stop_bit;
      repeat (BITLEN) @(negedge clock);
      rx = 1'b1;
   endtask

   task automatic check_drained(input string name);
      idle_cycles(4);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL %s missing_execute pending=%0d exp=0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      rx       = 1'b1;
      extReset = 1'b1;
      repeat (4) @(negedge clock);
      extReset = 1'b0;
      @(negedge clock);
      checks += 4;
      if (op !== 8'h00)          begin errors++; $display("FAIL reset_op got=%h exp=00", op); end
      if (data !== 32'h0)        begin errors++; $display("FAIL reset_data got=%h exp=00000000", data); end
      if (execute !== 1'b0)      begin errors++; $display("FAIL reset_execute got=%b exp=0", execute); end
      if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", framing_error); end
   endtask

   task automatic test_short();
      send_byte(8'h00, 1'b1, 1'b1, 8'h00, 32'h0000_0000);
      check_drained("short");
   endtask

   task automatic test_long();
      int e0;
      e0 = exec_cnt;
      send_byte(8'hC0, 1'b1, 1'b0, 8'h00, 32'h0);
      send_byte(8'h78, 1'b1, 1'b0, 8'h00, 32'h0);
      send_byte(8'h56, 1'b1, 1'b0, 8'h00, 32'h0);
      send_byte(8'h34, 1'b1, 1'b0, 8'h00, 32'h0);
      send_byte(8'h12, 1'b1, 1'b1, 8'hC0, 32'h1234_5678);
      check_drained("long");
      checks++;
      if (exec_cnt - e0 != 1) begin
         errors++;
         $display("FAIL long_exec_count got=%0d exp=1", exec_cnt - e0);
      end
   endtask

   task automatic test_glitch();
      int e0, f0;
      e0 = exec_cnt;
      f0 = fe_cnt;
      @(negedge clock);
      rx = 1'b0;
      repeat (5) @(negedge clock);
      idle_cycles(3 * BITLEN);
      checks += 2;
      if (exec_cnt != e0) begin errors++; $display("FAIL glitch_execute got=%0d exp=%0d", exec_cnt, e0); end
      if (fe_cnt != f0)   begin errors++; $display("FAIL glitch_ferr got=%0d exp=%0d", fe_cnt, f0); end
      send_byte(8'h33, 1'b1, 1'b1, 8'h33, 32'h1234_5678);
      check_drained("glitch_recover");
   endtask

   task automatic test_framing();
      int f0;
      f0 = fe_cnt;
      send_byte(8'h02, 1'b0, 1'b0, 8'h00, 32'h0);
      idle_cycles(2 * BITLEN);
      checks++;
      if (fe_cnt - f0 != 1) begin
         errors++;
         $display("FAIL framing_pulses got=%0d exp=1", fe_cnt - f0);
      end
      send_byte(8'h01, 1'b1, 1'b1, 8'h01, 32'h1234_5678);
      check_drained("framing_recover");
   endtask

   task automatic test_back_to_back();
      send_byte(8'h05, 1'b1, 1'b1, 8'h05, 32'h1234_5678);
      send_byte(8'h81, 1'b1, 1'b0, 8'h00, 32'h0);
      send_byte(8'h11, 1'b1, 1'b0, 8'h00, 32'h0);
      send_byte(8'h22, 1'b1, 1'b0, 8'h00, 32'h0);
      send_byte(8'h33, 1'b1, 1'b0, 8'h00, 32'h0);
      send_byte(8'h44, 1'b1, 1'b1, 8'h81, 32'h4433_2211);
      check_drained("back_to_back");
   endtask

   task automatic test_reset_mid_cmd();
      send_byte(8'hC0, 1'b1, 1'b0, 8'h00, 32'h0);
      send_byte(8'h11, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clock);
      extReset = 1'b1;
      repeat (2) @(negedge clock);
      extReset = 1'b0;
      @(negedge clock);
      checks += 2;
      if (op !== 8'h00)   begin errors++; $display("FAIL midreset_op got=%h exp=00", op); end
      if (data !== 32'h0) begin errors++; $display("FAIL midreset_data got=%h exp=00000000", data); end
      send_byte(8'h11, 1'b1, 1'b1, 8'h11, 32'h0000_0000);
      check_drained("after_reset");
   endtask

   task automatic test_timeout();
      send_byte(8'h80, 1'b1, 1'b0, 8'h00, 32'h0);
      send_byte(8'hAA, 1'b1, 1'b0, 8'h00, 32'h0);
      idle_cycles(40 * BITLEN);
`ifdef SERIAL_RX_TIMEOUT_EN
      send_byte(8'h02, 1'b1, 1'b1, 8'h02, 32'h0000_0000);
`else
      send_byte(8'h02, 1'b1, 1'b0, 8'h00, 32'h0);
      send_byte(8'h03, 1'b1, 1'b0, 8'h00, 32'h0);
      send_byte(8'h04, 1'b1, 1'b1, 8'h80, 32'h0403_02AA);
`endif
      check_drained("timeout");
   endtask

   initial begin
      test_reset();
      test_short();
      test_long();
      test_glitch();
      test_framing();
      test_back_to_back();
      test_reset_mid_cmd();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Run-time bound
   initial begin
      #2000000;
      $display("FAIL watchdog cycle=%0d exp=finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
